// File: rtl/mips32_alu_arbiter_if.sv
// Bundle of request, ALU-pin and response signals for mips32_alu_arbiter.
// Perf counter outputs exist only when ALU_ARB_PERF_EN is defined.
interface mips32_alu_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
`ifdef ALU_ARB_PERF_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_A0;
  logic [WIDTH-1:0] req_A1;
  logic [WIDTH-1:0] req_B0;
  logic [WIDTH-1:0] req_B1;
  logic [OP_W-1:0]  req_op0;
  logic [OP_W-1:0]  req_op1;

  logic [WIDTH-1:0] alu_A_in;
  logic [WIDTH-1:0] alu_B_in;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_less;
  logic             alu_of;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_less;
  logic             rsp_of;
  logic             rsp_err;

`ifdef ALU_ARB_PERF_EN
  logic [CNT_W-1:0] perf_grant0;
  logic [CNT_W-1:0] perf_grant1;
  logic [CNT_W-1:0] perf_stall;
`endif

  // Master: requesters, ALU and response consumer.
  modport master (
    output req_valid, req_A0, req_A1, req_B0, req_B1, req_op0, req_op1,
    output alu_out, alu_zero, alu_less, alu_of, rsp_ready,
    input  req_ready, alu_A_in, alu_B_in, alu_op,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_less, rsp_of, rsp_err
`ifdef ALU_ARB_PERF_EN
    ,
    input  perf_grant0, perf_grant1, perf_stall
`endif
  );

  // Slave: the arbiter itself.
  modport slave (
    input  req_valid, req_A0, req_A1, req_B0, req_B1, req_op0, req_op1,
    input  alu_out, alu_zero, alu_less, alu_of, rsp_ready,
    output req_ready, alu_A_in, alu_B_in, alu_op,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_less, rsp_of, rsp_err
`ifdef ALU_ARB_PERF_EN
    ,
    output perf_grant0, perf_grant1, perf_stall
`endif
  );
endinterface

// File: rtl/mips32_alu_arbiter.sv
// Round-robin arbiter sharing one external mips32_alu between two requesters.
// Define ALU_ARB_PERF_EN to add saturating grant/stall performance counters.
module mips32_alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 4
`ifdef ALU_ARB_PERF_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input logic                 clk,
  input logic                 rst,
  mips32_alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_less_q, rsp_less_d;
  logic             rsp_of_q, rsp_of_d;
  logic             rsp_err_q, rsp_err_d;

  logic             gnt_any;
  logic             gnt_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OP_W-1:0]  sel_op;
  logic             sel_illegal;

  // Grant is only offered in IDLE and never while reset is asserted.
  always_comb begin
    gnt_any     = (state_q == StIdle) && (bus.req_valid != 2'b00) && !rst;
    gnt_id      = (bus.req_valid == 2'b11) ? rr_q : bus.req_valid[1];
    sel_a       = gnt_id ? bus.req_A1 : bus.req_A0;
    sel_b       = gnt_id ? bus.req_B1 : bus.req_B0;
    sel_op      = gnt_id ? bus.req_op1 : bus.req_op0;
    sel_illegal = (sel_op == OP_W'(12)) || (sel_op == OP_W'(13));
  end

  assign bus.req_ready = !gnt_any ? 2'b00 : (gnt_id ? 2'b10 : 2'b01);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_less_d  = rsp_less_q;
    rsp_of_d    = rsp_of_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          rr_d     = ~gnt_id;
          rsp_id_d = gnt_id;
          if (sel_illegal) begin
            // ALU registers are left untouched so the ALU does not toggle.
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_zero_d  = 1'b0;
            rsp_less_d  = 1'b0;
            rsp_of_d    = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end else begin
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            alu_op_d  = sel_op;
            rsp_err_d = 1'b0;
            state_d   = StExec;
          end
        end
      end
      StExec: begin
        rsp_data_d  = bus.alu_out;
        rsp_zero_d  = bus.alu_zero;
        rsp_less_d  = bus.alu_less;
        rsp_of_d    = bus.alu_of;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_less_q  <= 1'b0;
      rsp_of_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_less_q  <= rsp_less_d;
      rsp_of_q    <= rsp_of_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.alu_A_in  = alu_a_q;
  assign bus.alu_B_in  = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_less  = rsp_less_q;
  assign bus.rsp_of    = rsp_of_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef ALU_ARB_PERF_EN
  logic [CNT_W-1:0] grant0_q, grant0_d;
  logic [CNT_W-1:0] grant1_q, grant1_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // All counters saturate at all-ones.
  always_comb begin
    grant0_d = grant0_q;
    grant1_d = grant1_q;
    stall_d  = stall_q;
    if (gnt_any && !gnt_id && (grant0_q != '1)) grant0_d = grant0_q + CNT_W'(1);
    if (gnt_any && gnt_id && (grant1_q != '1))  grant1_d = grant1_q + CNT_W'(1);
    if ((bus.req_valid != 2'b00) && (bus.req_ready == 2'b00) && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant0_q <= '0;
      grant1_q <= '0;
      stall_q  <= '0;
    end else begin
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.perf_grant0 = grant0_q;
  assign bus.perf_grant1 = grant1_q;
  assign bus.perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_mips32_alu_arbiter.sv
// Self-checking bench for mips32_alu_arbiter with a behavioural ALU and response model.
// Perf counter checks are compiled in when ALU_ARB_PERF_EN is defined.
module tb_mips32_alu_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned OP_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips32_alu_arbiter_if #(.WIDTH(WIDTH), .OP_W(OP_W)) ifc ();

  mips32_alu_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct packed {
    logic        of;
    logic        less;
    logic        zero;
    logic [31:0] res;
  } alu_res_t;

  typedef struct packed {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } req_t;

  int   checks = 0;
  int   failures = 0;
  logic model_rr = 1'b0;
  req_t exp_q[$];

  // ALU behaviour: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, other codes give 0.
  function automatic alu_res_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] op);
    alu_res_t r;
    r = '0;
    case (op)
      4'd0: r.res = a & b;
      4'd1: r.res = a | b;
      4'd2: begin
        r.res = a + b;
        r.of  = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      4'd6: begin
        r.res = a - b;
        r.of  = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      4'd7: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r.res = 32'd0;
    endcase
    r.zero = (r.res == 32'd0);
    r.less = $signed(a) < $signed(b);
    return r;
  endfunction

  // Expected response fields {id, err, of, less, zero, data} for a request.
  function automatic logic [36:0] expect_rsp(input req_t e);
    alu_res_t r;
    logic     ill;
    ill = (e.op == 4'd12) || (e.op == 4'd13);
    r   = ill ? '0 : alu_ref(e.a, e.b, e.op);
    return {e.id, ill, r.of, r.less, r.zero, r.res};
  endfunction

  always_comb begin
    alu_res_t r;
    r            = alu_ref(ifc.alu_A_in, ifc.alu_B_in, ifc.alu_op);
    ifc.alu_out  = r.res;
    ifc.alu_zero = r.zero;
    ifc.alu_less = r.less;
    ifc.alu_of   = r.of;
  end

  logic [36:0] rsp_obs;
  assign rsp_obs = {ifc.rsp_id, ifc.rsp_err, ifc.rsp_of, ifc.rsp_less, ifc.rsp_zero,
                    ifc.rsp_data};

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return 4'd6;
      4: return 4'd7;
      5: return 4'd12;
      default: return 4'd13;
    endcase
  endfunction

  task automatic rand_port(input logic p);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if (p) begin
      ifc.req_A1 = a; ifc.req_B1 = b; ifc.req_op1 = pick_op();
    end else begin
      ifc.req_A0 = a; ifc.req_B0 = b; ifc.req_op0 = pick_op();
    end
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (ifc.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 2'b00 || ifc.alu_A_in !== 32'd0 ||
        ifc.rsp_data !== 32'd0 || ifc.rsp_err !== 1'b0 || ifc.alu_op !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b ready=%b A=%h data=%h err=%b exp all zero",
               ifc.rsp_valid, ifc.req_ready, ifc.alu_A_in, ifc.rsp_data, ifc.rsp_err);
    end
    ifc.req_valid = 2'b11;
    #1;
    checks++;
    if (ifc.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL ready_in_reset got=%b exp=00", ifc.req_ready);
    end
    ifc.req_valid = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;
    ifc.req_A0 = 32'd9; ifc.req_B0 = 32'd4; ifc.req_op0 = 4'd2; ifc.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (ifc.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL first_grant got=%b exp=01", ifc.req_ready);
    end
    @(posedge clk); #1;
    rand_port(1'b1);
    ifc.req_valid = 2'b11;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 2'b00 || ifc.alu_A_in !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_exec got valid=%b ready=%b A=%h exp 0/00/0",
               ifc.rsp_valid, ifc.req_ready, ifc.alu_A_in);
    end
    @(posedge clk); #1;
    checks++;
    if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_held got valid=%b ready=%b exp 0/00", ifc.rsp_valid, ifc.req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ifc.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rr_after_reset got=%b exp=01", ifc.req_ready);
    end
    ifc.req_valid = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.rsp_valid !== 1'b0 || ifc.alu_A_in !== 32'd0) begin
      failures++;
      $display("FAIL valid_drop_no_latch got valid=%b A=%h exp 0/0", ifc.rsp_valid,
               ifc.alu_A_in);
    end
    model_rr = 1'b0;
  endtask

  task automatic test_single();
    int lat;
    bit ok;
    @(posedge clk); #1;
    ifc.req_A0 = 32'd5; ifc.req_B0 = 32'd3; ifc.req_op0 = 4'd2; ifc.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (ifc.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_grant got=%b exp=01", ifc.req_ready);
    end
    model_rr = 1'b1;
    @(posedge clk); #1;
    ifc.req_valid = 2'b00;
    wait_rsp(lat, ok);
    checks++;
    if (!ok || lat != 2) begin
      failures++;
      $display("FAIL single_latency got=%0d (seen=%0b) exp=2", lat, ok);
    end
    checks++;
    if (ifc.rsp_id !== 1'b0 || ifc.rsp_data !== 32'd8 || ifc.rsp_zero !== 1'b0 ||
        ifc.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp got id=%b data=%h zero=%b err=%b exp 0/8/0/0",
               ifc.rsp_id, ifc.rsp_data, ifc.rsp_zero, ifc.rsp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [31:0] a_prev;
    logic [31:0] b_prev;
    logic [3:0]  op_prev;
    a_prev = ifc.alu_A_in; b_prev = ifc.alu_B_in; op_prev = ifc.alu_op;
    ifc.req_A1 = $urandom; ifc.req_B1 = $urandom; ifc.req_op1 = 4'd12;
    ifc.req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (ifc.req_ready !== 2'b10) begin
      failures++;
      $display("FAIL illegal_grant got=%b exp=10", ifc.req_ready);
    end
    model_rr = 1'b0;
    @(posedge clk); #1;
    ifc.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (ifc.rsp_valid !== 1'b1 || rsp_obs !== {1'b1, 1'b1, 3'b000, 32'd0}) begin
      failures++;
      $display("FAIL illegal_rsp got valid=%b fields=%h exp valid=1 fields=%h",
               ifc.rsp_valid, rsp_obs, {1'b1, 1'b1, 3'b000, 32'd0});
    end
    checks++;
    if ({ifc.alu_A_in, ifc.alu_B_in, ifc.alu_op} !== {a_prev, b_prev, op_prev}) begin
      failures++;
      $display("FAIL illegal_alu_hold got=%h exp=%h",
               {ifc.alu_A_in, ifc.alu_B_in, ifc.alu_op}, {a_prev, b_prev, op_prev});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat;
    bit ok;
    ifc.req_A0 = 32'h7FFF_FFFF; ifc.req_B0 = 32'd1; ifc.req_op0 = 4'd2;
    ifc.req_valid = 2'b01;
    @(posedge clk); #1;
    ifc.req_valid = 2'b00;
    model_rr = 1'b1;
    wait_rsp(lat, ok);
    checks++;
    if (!ok || rsp_obs !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0000}) begin
      failures++;
      $display("FAIL overflow_rsp got seen=%0b fields=%h exp=%h", ok, rsp_obs,
               {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0000});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   rsps;
    bit   busy;
    logic g;
    logic granted;
    logic [1:0] exp_rdy;
    req_t e;
    rsps = 0;
    busy = 1'b0;
    rand_port(1'b0);
    rand_port(1'b1);
    ifc.req_valid = 2'b11;
    ifc.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && rsps < 12; cyc++) begin
      @(negedge clk);
      granted = 1'b0;
      g       = model_rr;
      exp_rdy = busy ? 2'b00 : (model_rr ? 2'b10 : 2'b01);
      checks++;
      if (ifc.req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rr_ready cyc=%0d got=%b exp=%b", cyc, ifc.req_ready, exp_rdy);
      end
      if (!busy) begin
        e.id = g;
        e.a  = g ? ifc.req_A1 : ifc.req_A0;
        e.b  = g ? ifc.req_B1 : ifc.req_B0;
        e.op = g ? ifc.req_op1 : ifc.req_op0;
        exp_q.push_back(e);
        model_rr = ~g;
        busy     = 1'b1;
        granted  = 1'b1;
      end else if (ifc.rsp_valid && ifc.rsp_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (rsp_obs !== expect_rsp(e)) begin
          failures++;
          $display("FAIL rr_rsp n=%0d got=%h exp=%h", rsps, rsp_obs, expect_rsp(e));
        end
        rsps++;
        busy = 1'b0;
      end
      @(posedge clk); #1;
      if (granted) rand_port(g);
      ifc.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    checks++;
    if (rsps < 12) begin
      failures++;
      $display("FAIL rr_timeout got=%0d responses exp=12", rsps);
    end
    ifc.req_valid = 2'b00;
    ifc.rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int          lat;
    bit          ok;
    logic [36:0] snap;
    req_t        e0;
    req_t        e1;
    rst = 1'b1;
    ifc.req_valid = 2'b00;
    ifc.rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rr = 1'b0;
    e0 = '{id: 1'b0, a: $urandom, b: $urandom, op: 4'd2};
    ifc.req_A0 = e0.a; ifc.req_B0 = e0.b; ifc.req_op0 = e0.op;
    ifc.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (ifc.req_ready !== 2'b01) begin
      failures++;
      $display("FAIL bp_grant0 got=%b exp=01", ifc.req_ready);
    end
    @(posedge clk); #1;
    e1 = '{id: 1'b1, a: $urandom, b: $urandom, op: 4'd6};
    ifc.req_A1 = e1.a; ifc.req_B1 = e1.b; ifc.req_op1 = e1.op;
    ifc.req_valid = 2'b11;
    wait_rsp(lat, ok);
    checks++;
    if (!ok || rsp_obs !== expect_rsp(e0)) begin
      failures++;
      $display("FAIL bp_rsp0 got seen=%0b fields=%h exp=%h", ok, rsp_obs, expect_rsp(e0));
    end
    snap = expect_rsp(e0);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (ifc.rsp_valid !== 1'b1 || ifc.req_ready !== 2'b00 || rsp_obs !== snap) begin
        failures++;
        $display("FAIL bp_hold k=%0d got valid=%b ready=%b fields=%h exp 1/00/%h", k,
                 ifc.rsp_valid, ifc.req_ready, rsp_obs, snap);
      end
`ifdef ALU_ARB_PERF_EN
      checks++;
      if (ifc.perf_stall !== 16'(k)) begin
        failures++;
        $display("FAIL bp_perf_stall k=%0d got=%0d exp=%0d", k, ifc.perf_stall, k);
      end
`endif
      if (k < 10) @(negedge clk);
    end
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.req_ready !== 2'b10) begin
      failures++;
      $display("FAIL bp_next_grant got=%b exp=10", ifc.req_ready);
    end
`ifdef ALU_ARB_PERF_EN
    checks++;
    if (ifc.perf_stall !== 16'd11 || ifc.perf_grant0 !== 16'd1 ||
        ifc.perf_grant1 !== 16'd0) begin
      failures++;
      $display("FAIL bp_perf_counts got stall=%0d g0=%0d g1=%0d exp 11/1/0",
               ifc.perf_stall, ifc.perf_grant0, ifc.perf_grant1);
    end
`endif
    @(posedge clk); #1;
    ifc.req_valid = 2'b00;
    model_rr = 1'b0;
    wait_rsp(lat, ok);
    checks++;
    if (!ok || lat != 2 || rsp_obs !== expect_rsp(e1)) begin
      failures++;
      $display("FAIL bp_rsp1 got seen=%0b lat=%0d fields=%h exp lat=2 fields=%h", ok, lat,
               rsp_obs, expect_rsp(e1));
    end
`ifdef ALU_ARB_PERF_EN
    checks++;
    if (ifc.perf_grant1 !== 16'd1) begin
      failures++;
      $display("FAIL bp_perf_grant1 got=%0d exp=1", ifc.perf_grant1);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    ifc.req_valid = 2'b00;
    ifc.req_A0    = '0;
    ifc.req_A1    = '0;
    ifc.req_B0    = '0;
    ifc.req_B1    = '0;
    ifc.req_op0   = '0;
    ifc.req_op1   = '0;
    ifc.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_illegal();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
